// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage.
// Optional perf counters are enabled with PIPE_STAGE_PERF_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_FULL,
    PS_SKID
  } pipe_state_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle carrying a control word and a payload.
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_stage_skid_if #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 128
);

  logic                  valid;
  logic                  ready;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One storage slot: valid + ctrl + data register.
// clr wipes to NOP/0, load captures, drop invalidates but keeps data.
module pipe_slot #(
  parameter int                    CTRL_WIDTH = 16,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  drop_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid so ready is registered.
// Define PIPE_STAGE_PERF_EN to add stall/bubble/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                    CTRL_WIDTH = 16,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  pipe_stage_skid_if.slave       in_if,
  pipe_stage_skid_if.master      out_if
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]  stall_cnt,
  output logic [PERF_CNT_W-1:0]  bubble_cnt,
  output logic [PERF_CNT_W-1:0]  flush_cnt
`endif
);

  pipe_state_t state_q, state_d;

  logic                  main_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;

  logic                  main_load;
  logic                  main_drop;
  logic                  main_from_skid;
  logic                  skid_load;
  logic                  skid_drop;
  logic [CTRL_WIDTH-1:0] main_ctrl_in;
  logic [DATA_WIDTH-1:0] main_data_in;

  logic in_fire;
  logic out_fire;

  // ready depends only on the skid register, never on out_if.ready
  assign in_if.ready = ~skid_valid;
  assign in_fire     = in_if.valid & ~skid_valid;
  assign out_fire    = main_valid & out_if.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (flush_i) begin
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = PS_FULL;
          end
        end
        PS_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = PS_SKID;
          end else if (out_fire) begin
            main_drop = 1'b1;
            state_d   = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_d        = PS_FULL;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_if.ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_if.data;

  pipe_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_NOP   (CTRL_NOP)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  pipe_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_NOP   (CTRL_NOP)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .load_i  (skid_load),
    .drop_i  (skid_drop),
    .ctrl_i  (in_if.ctrl),
    .data_i  (in_if.data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  assign out_if.valid = main_valid;
  assign out_if.ctrl  = main_ctrl;
  assign out_if.data  = main_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q;
  logic [PERF_CNT_W-1:0] bubble_q;
  logic [PERF_CNT_W-1:0] flush_q;

  // counters wrap naturally and survive flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (main_valid && !out_if.ready) begin
        stall_q <= stall_q + 1'b1;
      end
      if (!main_valid) begin
        bubble_q <= bubble_q + 1'b1;
      end
      if (flush_i) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios plus random traffic.
// The reference model is a 2-deep FIFO of accepted entries.
module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 128;
  localparam logic [CW-1:0] NOP = '0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;

  pipe_stage_skid_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) up ();
  pipe_stage_skid_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dn ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [31:0] e_stall, e_bubble, e_flush;
`endif

  pipe_stage_skid #(
    .CTRL_WIDTH (CW),
    .DATA_WIDTH (DW),
    .CTRL_NOP   (NOP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .in_if   (up),
    .out_if  (dn)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ent_t q[$];
  ent_t src_q[$];
  logic [31:0] dlv[$];
  int dlv_cyc[$];
  bit zero_data = 1'b1;
  bit lif = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ent_t mk(input int id);
    ent_t e;
    e.c = CW'($urandom);
    e.d = {$urandom, $urandom, $urandom, 32'(id)};
    return e;
  endfunction

  // monitor: compare against the FIFO model, then advance it for the next edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      zero_data = 1'b1;
      lif = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
      e_stall = 0;
      e_bubble = 0;
      e_flush = 0;
`endif
    end else begin
      bit lof;
      chk("in_ready", DW'(up.ready), DW'(q.size() < 2));
      chk("out_valid", DW'(dn.valid), DW'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_ctrl", DW'(dn.ctrl), DW'(q[0].c));
        chk("out_data", dn.data, q[0].d);
      end else begin
        chk("idle_ctrl", DW'(dn.ctrl), DW'(NOP));
        if (zero_data) chk("idle_data", dn.data, '0);
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(e_stall));
      chk("bubble_cnt", DW'(bubble_cnt), DW'(e_bubble));
      chk("flush_cnt", DW'(flush_cnt), DW'(e_flush));
      if (q.size() > 0 && !dn.ready) e_stall++;
      if (q.size() == 0) e_bubble++;
      if (flush_i) e_flush++;
`endif
      lif = up.valid && (q.size() < 2);
      lof = (q.size() > 0) && dn.ready;
      if (lof) begin
        dlv.push_back(q[0].d[31:0]);
        dlv_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (flush_i) begin
        q.delete();
        zero_data = 1'b1;
      end else if (lif) begin
        q.push_back('{c: up.ctrl, d: up.data});
        zero_data = 1'b0;
      end
    end
  end

  task automatic step(input bit rdy, input int vpct, input bit fl);
    @(posedge clk);
    #1;
    if (up.valid && lif) begin
      void'(src_q.pop_front());
      up.valid = 1'b0;
    end
    if (!up.valid && src_q.size() > 0 &&
        $urandom_range(99) < vpct) begin
      up.valid = 1'b1;
      up.ctrl  = src_q[0].c;
      up.data  = src_q[0].d;
    end
    dn.ready = rdy;
    flush_i  = fl;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (src_q.size() == 0 && q.size() == 0 && !up.valid) break;
      step(1'b1, 100, 1'b0);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_valid", DW'(dn.valid), '0);
    chk("rst_ctrl", DW'(dn.ctrl), DW'(NOP));
    chk("rst_data", dn.data, '0);
    chk("rst_ready", DW'(up.ready), DW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    up.valid = 1'b0;
    up.ctrl  = '0;
    up.data  = '0;
    dn.ready = 1'b0;
    #2;
    chk("por_valid", DW'(dn.valid), '0);
    chk("por_ctrl", DW'(dn.ctrl), DW'(NOP));
    chk("por_data", dn.data, '0);
    chk("por_ready", DW'(up.ready), DW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // streaming 1..8 back to back
    for (int i = 1; i <= 8; i++) src_q.push_back(mk(i));
    base = dlv.size();
    repeat (14) step(1'b1, 100, 1'b0);
    chk("stream_cnt", DW'(dlv.size() - base), DW'(8));
    if (dlv.size() >= base + 8) begin
      for (int k = 0; k < 8; k++)
        chk("stream_ord", DW'(dlv[base+k]), DW'(k + 1));
      chk("stream_gap", DW'(dlv_cyc[base+7] - dlv_cyc[base]), DW'(7));
    end

    // stall: 3 offered, 2 accepted, then release
    drain();
    for (int i = 1; i <= 3; i++) src_q.push_back(mk(i));
    repeat (6) step(1'b0, 100, 1'b0);
    @(negedge clk);
    chk("stall_ready", DW'(up.ready), '0);
    chk("stall_hold", DW'(dn.data[31:0]), DW'(1));
    base = dlv.size();
    repeat (8) step(1'b1, 100, 1'b0);
    chk("stall_cnt", DW'(dlv.size() - base), DW'(3));
    if (dlv.size() >= base + 3) begin
      for (int k = 0; k < 3; k++)
        chk("stall_ord", DW'(dlv[base+k]), DW'(k + 1));
    end

    // flush with skid full (5,6) and 7 pending
    drain();
    for (int i = 5; i <= 7; i++) src_q.push_back(mk(i));
    repeat (3) step(1'b0, 100, 1'b0);
    step(1'b0, 100, 1'b1);
    base = dlv.size();
    step(1'b1, 0, 1'b0);
    src_q.delete();
    up.valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", DW'(dn.valid), '0);
    chk("flush_ctrl", DW'(dn.ctrl), DW'(NOP));
    chk("flush_data", dn.data, '0);
    repeat (4) step(1'b1, 0, 1'b0);
    chk("flush_lost", DW'(dlv.size() - base), '0);

    // flush together with delivery of 9, then 10
    src_q.push_back(mk(9));
    step(1'b1, 100, 1'b0);
    base = dlv.size();
    step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b0);
    chk("fh_cnt", DW'(dlv.size() - base), DW'(1));
    if (dlv.size() > base) chk("fh_9", DW'(dlv[base]), DW'(9));
    src_q.push_back(mk(10));
    repeat (4) step(1'b1, 100, 1'b0);
    if (dlv.size() > 0) chk("fh_10", DW'(dlv[dlv.size()-1]), DW'(10));

    // reset in the middle of a stalled stream
    for (int i = 20; i < 24; i++) src_q.push_back(mk(i));
    repeat (4) step(1'b0, 100, 1'b0);
    mid_reset();
    src_q.delete();
    up.valid = 1'b0;
    repeat (3) step(1'b1, 0, 1'b0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (src_q.size() < 4) src_q.push_back(mk(1000 + i));
      step($urandom_range(99) < 70, 60, $urandom_range(99) < 3);
    end
    drain();
    step(1'b1, 0, 1'b0);
    @(negedge clk);
    chk("end_empty", DW'(dn.valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
